// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code enum (also used by the ALU controller),
// execute-stage FSM states and the shift-op classifier.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SLT  = 4'b0101,
    OP_XOR  = 4'b0110,
    OP_SRL  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_NOR  = 4'b1001,
    OP_BEQ  = 4'b1010,
    OP_BNE  = 4'b1011,
    OP_SLTU = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  // True for the ops that run through the iterative shifter.
  function automatic logic is_shift(alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle combinational datapath for every non-shift op.
// Ports:
//   i_op        op code (undefined codes give result 0, branch 0)
//   i_a, i_b    operands
//   o_result_c  op result (shift ops also return 0 here)
//   o_branch_c  branch condition, only set for BEQ/BNE
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  alu_op_e               i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_result_c,
  output logic                  o_branch_c
);

  logic w_lt_s;
  logic w_lt_u;
  logic w_eq;

  assign w_lt_s = $signed(i_a) < $signed(i_b);
  assign w_lt_u = i_a < i_b;
  assign w_eq   = i_a == i_b;

  // Op decode; shift and undefined codes fall through to zero.
  always_comb begin
    o_result_c = '0;
    o_branch_c = 1'b0;
    case (i_op)
      OP_AND:  o_result_c = i_a & i_b;
      OP_OR:   o_result_c = i_a | i_b;
      OP_ADD:  o_result_c = i_a + i_b;
      OP_SUB:  o_result_c = i_a - i_b;
      OP_XOR:  o_result_c = i_a ^ i_b;
      OP_NOR:  o_result_c = ~(i_a | i_b);
      OP_SLT:  o_result_c = DATA_WIDTH'(w_lt_s);
      OP_SLTU: o_result_c = DATA_WIDTH'(w_lt_u);
      OP_BEQ: begin
        o_result_c = i_a - i_b;
        o_branch_c = w_eq;
      end
      OP_BNE: begin
        o_result_c = i_a - i_b;
        o_branch_c = ~w_eq;
      end
      default: begin
        o_result_c = '0;
        o_branch_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU with single-cycle logic/arith/compare/branch ops and an
// iterative one-bit-per-cycle shifter, valid/ready on both sides.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   upstream handshake (accept = in_valid & in_ready)
//   Operation, SrcA, SrcB op code and operands, captured at accept
//   out_valid / out_ready downstream handshake
//   ALUResult, Zero       registered result and its zero flag
//   Branch                registered branch condition (BEQ/BNE)
module alu_iter_exec
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero,
  output logic                  Branch
);

  alu_state_e            r_state;
  alu_state_e            w_state_nxt;
  alu_op_e               r_op;
  logic [DATA_WIDTH-1:0] r_work;
  logic [SHAMT_W-1:0]    r_cnt;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;
  logic                  r_branch;

  alu_op_e               w_op;
  logic [SHAMT_W-1:0]    w_shamt;
  logic                  w_is_shift;
  logic                  w_shift_start;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_last_shift;
  logic [DATA_WIDTH-1:0] w_comb_result;
  logic                  w_comb_branch;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_work_shifted;

  assign w_op          = alu_op_e'(Operation);
  assign w_shamt       = SrcB[SHAMT_W-1:0];
  assign w_is_shift    = is_shift(w_op);
  assign w_shift_start = w_is_shift && (w_shamt != '0);
  assign w_last_shift  = (r_cnt == SHAMT_W'(1));

  alu_comb #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu_comb (
    .i_op      (w_op),
    .i_a       (SrcA),
    .i_b       (SrcB),
    .o_result_c(w_comb_result),
    .o_branch_c(w_comb_branch)
  );

  // A zero-amount shift completes immediately with SrcA unchanged.
  assign w_load = w_is_shift ? SrcA : w_comb_result;

  // One-bit step of the working register for the captured shift op.
  always_comb begin
    w_work_shifted = r_work;
    case (r_op)
      OP_SLL:  w_work_shifted = {r_work[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  w_work_shifted = {1'b0, r_work[DATA_WIDTH-1:1]};
      default: w_work_shifted = {r_work[DATA_WIDTH-1], r_work[DATA_WIDTH-1:1]};
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode; an accept in IDLE or DONE wins.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: w_in_ready = 1'b1;
      ST_SHIFT: begin
        if (w_last_shift) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_in_ready = out_ready;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_accept = in_valid & w_in_ready;
    if (w_accept) w_state_nxt = w_shift_start ? ST_SHIFT : ST_DONE;
  end

  // Working shifter, counter and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op        <= OP_AND;
      r_work      <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_branch    <= 1'b0;
    end else if (w_accept) begin
      if (w_shift_start) begin
        r_op        <= w_op;
        r_work      <= SrcA;
        r_cnt       <= w_shamt;
        r_out_valid <= 1'b0;
      end else begin
        r_result    <= w_load;
        r_zero      <= (w_load == '0);
        r_branch    <= w_comb_branch;
        r_out_valid <= 1'b1;
      end
    end else if (r_state == ST_SHIFT) begin
      r_work <= w_work_shifted;
      r_cnt  <= r_cnt - SHAMT_W'(1);
      if (w_last_shift) begin
        r_result    <= w_work_shifted;
        r_zero      <= (w_work_shifted == '0);
        r_branch    <= 1'b0;
        r_out_valid <= 1'b1;
      end
    end else if ((r_state == ST_DONE) && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign ALUResult = r_result;
  assign Zero      = r_zero;
  assign Branch    = r_branch;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed self-checking bench for alu_iter_exec.
module tb_alu_iter_exec;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        Branch;

  int n_checks;
  int n_pass;

  alu_iter_exec #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Operation(Operation),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALUResult(ALUResult),
    .Zero     (Zero),
    .Branch   (Branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op with out_ready low, scramble the inputs after accept and
  // count cycles until out_valid (lat) and cycles with in_ready low.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat, output int rdy_low);
    in_valid  = 1'b1;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    out_ready = 1'b0;
    tick();
    in_valid  = 1'b0;
    Operation = 4'b0001;
    SrcA      = 32'hDEAD_BEEF;
    SrcB      = 32'h0000_0013;
    lat       = 1;
    rdy_low   = 0;
    while (!out_valid && lat < 100) begin
      if (!in_ready) rdy_low++;
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    Operation = 4'b0; SrcA = '0; SrcB = '0;
    tick(); tick();
    n_checks++;
    if ({out_valid, ALUResult, Zero, Branch, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset: ov=%b res=%h z=%b br=%b ir=%b, want 0 0 0 0 1",
               out_valid, ALUResult, Zero, Branch, in_ready);
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_wrap();
    in_valid = 1'b1; Operation = OP_ADD; SrcA = 32'hFFFF_FFFF; SrcB = 32'h1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, ALUResult, Zero, Branch} !== {1'b1, 32'h0, 1'b1, 1'b0})
      $display("FAIL add_wrap: ov=%b res=%h z=%b br=%b, want 1 0 1 0",
               out_valid, ALUResult, Zero, Branch);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL add_drain: ov=%b, want 0", out_valid);
    else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_shift();
    int lat, rl;
    run_op(OP_SRA, 32'h8000_0000, 32'd4, lat, rl);
    n_checks++;
    if (lat !== 5 || rl !== 4 || ALUResult !== 32'hF800_0000 || Zero !== 1'b0 || Branch !== 1'b0)
      $display("FAIL sra4: lat=%0d rdylow=%0d res=%h z=%b br=%b, want 5 4 f8000000 0 0",
               lat, rl, ALUResult, Zero, Branch);
    else n_pass++;
    consume();
    run_op(OP_SRL, 32'h8000_0000, 32'd4, lat, rl);
    n_checks++;
    if (lat !== 5 || ALUResult !== 32'h0800_0000)
      $display("FAIL srl4: lat=%0d res=%h, want 5 08000000", lat, ALUResult);
    else n_pass++;
    consume();
    run_op(OP_SLL, 32'h0000_1234, 32'h0000_0020, lat, rl);
    n_checks++;
    if (lat !== 1 || ALUResult !== 32'h0000_1234)
      $display("FAIL sll0: lat=%0d res=%h, want 1 00001234", lat, ALUResult);
    else n_pass++;
    consume();
    run_op(OP_SLL, 32'h1, 32'd31, lat, rl);
    n_checks++;
    if (lat !== 32 || rl !== 31 || ALUResult !== 32'h8000_0000)
      $display("FAIL sll31: lat=%0d rdylow=%0d res=%h, want 32 31 80000000", lat, rl, ALUResult);
    else n_pass++;
    consume();
  endtask

  task automatic test_branch_cmp();
    logic [3:0]  ops [7];
    logic [31:0] as  [7];
    logic [31:0] bs  [7];
    logic [31:0] res [7];
    logic        zs  [7];
    logic        brs [7];
    int lat, rl;
    ops = '{OP_BEQ, OP_BNE, OP_SLT, OP_SLTU, OP_NOR, OP_SUB, 4'b1101};
    as  = '{32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0F0F_0000, 32'd3, 32'h1234_5678};
    bs  = '{32'd5, 32'd7, 32'd1, 32'd1, 32'h0000_00FF, 32'd10, 32'h1234_5678};
    res = '{32'h0, 32'hFFFF_FFFE, 32'h1, 32'h0, 32'hF0F0_FF00, 32'hFFFF_FFF9, 32'h0};
    zs  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    brs = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], as[i], bs[i], lat, rl);
      n_checks++;
      if (lat !== 1 || ALUResult !== res[i] || Zero !== zs[i] || Branch !== brs[i])
        $display("FAIL op%0d(%b): lat=%0d res=%h z=%b br=%b, want 1 %h %b %b",
                 i, ops[i], lat, ALUResult, Zero, Branch, res[i], zs[i], brs[i]);
      else n_pass++;
      consume();
    end
  endtask

  task automatic test_hold();
    int lat, rl;
    run_op(OP_OR, 32'h0000_00F0, 32'h0000_000F, lat, rl);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({out_valid, ALUResult, in_ready} !== {1'b1, 32'h0000_00FF, 1'b0})
        $display("FAIL hold%0d: ov=%b res=%h ir=%b, want 1 000000ff 0",
                 c, out_valid, ALUResult, in_ready);
      else n_pass++;
      tick();
    end
    out_ready = 1'b1; in_valid = 1'b1; Operation = OP_ADD; SrcA = 32'd2; SrcB = 32'd3;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL done_ready: ir=%b, want 1", in_ready);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || ALUResult !== 32'd5)
      $display("FAIL same_cycle_accept: ov=%b res=%h, want 1 00000005", out_valid, ALUResult);
    else n_pass++;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [4];
    logic [31:0] as  [4];
    logic [31:0] bs  [4];
    logic [31:0] res [4];
    ops = '{OP_ADD, OP_SUB, OP_XOR, OP_AND};
    as  = '{32'd1, 32'd10, 32'h0000_000F, 32'hFF00_FF00};
    bs  = '{32'd2, 32'd3, 32'h0000_0003, 32'h0F0F_0F0F};
    res = '{32'd3, 32'd7, 32'h0000_000C, 32'h0F00_0F00};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; Operation = ops[i]; SrcA = as[i]; SrcB = bs[i];
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || ALUResult !== res[i])
        $display("FAIL b2b%0d: ov=%b res=%h, want 1 %h", i, out_valid, ALUResult, res[i]);
      else n_pass++;
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    in_valid = 1'b1; Operation = OP_SRL; SrcA = 32'hFFFF_FFFF; SrcB = 32'd20; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({out_valid, ALUResult, in_ready} !== {1'b0, 32'h0, 1'b1})
      $display("FAIL rst_mid_shift: ov=%b res=%h ir=%b, want 0 0 1", out_valid, ALUResult, in_ready);
    else n_pass++;
    rst_n = 1'b1; out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL stale_result: valid cycles=%0d, want 0", seen);
    else n_pass++;
    out_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_add_wrap();
    test_shift();
    test_branch_cmp();
    test_hold();
    test_back_to_back();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
